instr_fetch: RTL

Fetch stage directly upstream of the core decoder. It drives the read port of the instruction BRAM (bram32), absorbs its 1-cycle read latency, and presents {pc, instruction} to the decoder over a valid/ready handshake. It supports redirects on branch/jump and holds sequential fetch under decoder backpressure without losing or duplicating instructions.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/fetch_buf2.sv | 77 +++++++
 rtl/instr_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam int          DEFAULT_ADDR_W     = 10;
    localparam int          I_BRAM_DEPTH       = 1 << DEFAULT_ADDR_W;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES        = 32'd4;

    typedef logic [31:0] pc_t;

    // A redirect target that is not word aligned cannot be fetched.
    function automatic logic pc_misaligned(input pc_t pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry {pc, instr} FIFO sitting between the BRAM return path and the
// decoder handshake. Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_buf2
    import instr_fetch_pkg::*;
#(
    parameter int DW = DEFAULT_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  pc_t           push_pc_i,
    input  logic [DW-1:0] push_instr_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [1:0]    count_o,
    output pc_t           head_pc_o,
    output logic [DW-1:0] head_instr_o
);

    pc_t           pc0_q, pc0_d, pc1_q, pc1_d;
    logic [DW-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [1:0]    count_q, count_d;
    logic          doPop, doPush;
    logic [1:0]    wrSlot;

    // Next-state: flush beats everything, otherwise shift on pop and write the first free slot on push.
    always_comb begin
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        count_d  = count_q;
        doPop    = pop_i && (count_q != 2'd0);
        doPush   = push_i && ((count_q != 2'd2) || doPop);
        wrSlot   = count_q - {1'b0, doPop};
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (doPop) begin
                pc0_d    = pc1_q;
                instr0_d = instr1_q;
            end
            if (doPush) begin
                if (wrSlot == 2'd0) begin
                    pc0_d    = push_pc_i;
                    instr0_d = push_instr_i;
                end else begin
                    pc1_d    = push_pc_i;
                    instr1_d = push_instr_i;
                end
            end
            count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    // Storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc0_q    <= '0;
            pc1_q    <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = (count_q != 2'd0) ? pc0_q : '0;
    assign head_instr_o = (count_q != 2'd0) ? instr0_q : '0;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues BRAM reads, absorbs the one-cycle read latency and
// hands {pc, instr} to the decoder. An epoch bit tags each request so data
// returning after a redirect is discarded instead of entering the buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          ADDR_W     = DEFAULT_ADDR_W,
    parameter int          DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_W-1:0]     bram_r_addr,
    output logic                  bram_r_enb,
    input  logic [DATA_WIDTH-1:0] bram_r_dat,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_pc,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic                  fetch_fault
);

    pc_t        fetch_pc_q, fetch_pc_d;
    pc_t        inflight_pc_q, inflight_pc_d;
    logic       inflight_q, inflight_d;
    logic       inflight_epoch_q, inflight_epoch_d;
    logic       epoch_q, epoch_d;
    logic       fault_q, fault_d;
    logic [1:0] bufCount;
    logic       pop, push, issue;
    logic [2:0] occupancy;

    // Slots already committed (in flight plus buffered) after this cycle's pop; never allow more than two.
    assign pop       = if_valid && if_ready;
    assign occupancy = {2'b00, inflight_q} + {1'b0, bufCount} - {2'b00, pop};
    assign issue     = rst && fetch_en && !fault_q && !redirect_valid && (occupancy < 3'd2);
    assign push      = inflight_q && (inflight_epoch_q == epoch_q);

    fetch_buf2 #(
        .DW(DATA_WIDTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (bram_r_dat),
        .pop_i        (pop && !redirect_valid),
        .flush_i      (redirect_valid),
        .count_o      (bufCount),
        .head_pc_o    (if_pc),
        .head_instr_o (if_instr)
    );

    // Next-state for the PC, in-flight tag, epoch and fault flag; a redirect overrides sequential advance.
    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_d       = issue;
        inflight_pc_d    = inflight_pc_q;
        inflight_epoch_d = inflight_epoch_q;
        epoch_d          = epoch_q;
        fault_d          = fault_q;
        if (issue) begin
            fetch_pc_d       = fetch_pc_q + INSTR_BYTES;
            inflight_pc_d    = fetch_pc_q;
            inflight_epoch_d = epoch_q;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            epoch_d    = ~epoch_q;
            fault_d    = pc_misaligned(redirect_pc);
        end
    end

    // Control registers with synchronous active-low reset; reset wins over any redirect or return.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
            fault_q          <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_epoch_q <= inflight_epoch_d;
            epoch_q          <= epoch_d;
            fault_q          <= fault_d;
        end
    end

    assign bram_r_addr = fetch_pc_q[ADDR_W+1:2];
    assign bram_r_enb  = issue;
    assign if_valid    = (bufCount != 2'd0);
    assign fetch_fault = fault_q;

endmodule
